dac_instr_tx: RTL

Serial DAC instruction transmitter between the output-processing (OPP) stage and the 8-channel 16-bit SPI DAC. Latches per-channel DAC codes from OPP, arbitrates round-robin among pending channels, and shifts 32-bit write instructions out on `dac_sclk_out`/`dac_din_out` framed by `dac_nsync_out`. After each write it pulses `dac_nldac_out`. It also issues the one-shot internal-reference-enable command on request.

---
 rtl/dac_instr_tx_if.sv | 34 +++
 rtl/dac_instr_tx.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/dac_instr_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : dac_instr_tx_if
// Purpose  : OPP-side code/strobe bus and DAC serial pins of dac_instr_tx.
// Revision : 1.0 - initial release
// ============================================================================
interface dac_instr_tx_if #(
    parameter int N_CHAN = 8,
    parameter int W_DATA = 16
);
    logic [N_CHAN-1:0]        data_valid_in;
    logic [N_CHAN*W_DATA-1:0] data_in;
    logic                     ref_set_in;
    logic                     dac_nsync_out;
    logic                     dac_sclk_out;
    logic                     dac_din_out;
    logic                     dac_nldac_out;
    logic                     dac_nclr_out;
    logic                     busy_out;
    logic [N_CHAN-1:0]        done_out;

    modport master (
        output data_valid_in, data_in, ref_set_in,
        input  dac_nsync_out, dac_sclk_out, dac_din_out, dac_nldac_out,
        input  dac_nclr_out, busy_out, done_out
    );

    modport slave (
        input  data_valid_in, data_in, ref_set_in,
        output dac_nsync_out, dac_sclk_out, dac_din_out, dac_nldac_out,
        output dac_nclr_out, busy_out, done_out
    );
endinterface
`default_nettype wire

// File: rtl/dac_instr_tx.sv
`default_nettype none
// ============================================================================
// Module   : dac_instr_tx
// Purpose  : Latches per-channel DAC codes and shifts round-robin SPI writes.
// Revision : 1.0 - initial release
// ============================================================================
module dac_instr_tx #(
    parameter int N_CHAN      = 8,
    parameter int W_DATA      = 16,
    parameter int SCLK_DIV    = 1,
    parameter int SYNC_HI_CYC = 2,
    parameter int LDAC_CYC    = 2
) (
    input  logic          clk_in,
    input  logic          rst_in,
    dac_instr_tx_if.slave bus
);
    localparam int          c_cw        = (N_CHAN > 1) ? $clog2(N_CHAN) : 1;
    localparam logic [7:0]  c_div_last  = 8'(SCLK_DIV - 1);
    localparam logic [7:0]  c_sync_last = 8'(SYNC_HI_CYC - 1);
    localparam logic [7:0]  c_ldac_last = 8'(LDAC_CYC - 1);
    localparam logic [31:0] c_ref_instr = 32'h0800_0001;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_SHIFT   = 3'd2,
        S_SYNC_HI = 3'd3,
        S_LDAC    = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [W_DATA-1:0] shadow_q [N_CHAN];
    logic [W_DATA-1:0] shadow_d [N_CHAN];
    logic [N_CHAN-1:0] pending_q, pending_d;
    logic              ref_pending_q, ref_pending_d;
    logic [c_cw-1:0]   rr_ptr_q, rr_ptr_d;
    logic [c_cw-1:0]   chan_q, chan_d;
    logic              is_ref_q, is_ref_d;
    logic [31:0]       instr_q, instr_d;
    logic [4:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        div_cnt_q, div_cnt_d;
    logic [7:0]        cyc_cnt_q, cyc_cnt_d;
    logic              nsync_q, nsync_d;
    logic              sclk_q, sclk_d;
    logic              din_q, din_d;
    logic              nldac_q, nldac_d;
    logic [N_CHAN-1:0] done_q, done_d;

    logic              grant_found;
    logic [c_cw-1:0]   grant_idx;

    // First pending channel at or after the round-robin pointer.
    always_comb begin
        logic [c_cw-1:0] cand;
        cand        = '0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < N_CHAN; k++) begin
            cand = c_cw'((int'(rr_ptr_q) + k) % N_CHAN);
            if (!grant_found && pending_q[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        logic start_frame;
        start_frame   = 1'b0;
        state_d       = state_q;
        shadow_d      = shadow_q;
        pending_d     = pending_q;
        ref_pending_d = ref_pending_q;
        rr_ptr_d      = rr_ptr_q;
        chan_d        = chan_q;
        is_ref_d      = is_ref_q;
        instr_d       = instr_q;
        bit_cnt_d     = bit_cnt_q;
        div_cnt_d     = div_cnt_q;
        cyc_cnt_d     = cyc_cnt_q;
        nsync_d       = nsync_q;
        sclk_d        = sclk_q;
        din_d         = din_q;
        nldac_d       = nldac_q;
        done_d        = '0;

        unique case (state_q)
            S_IDLE: begin
                if (ref_pending_q) begin
                    ref_pending_d = 1'b0;
                    is_ref_d      = 1'b1;
                    instr_d       = c_ref_instr;
                    start_frame   = 1'b1;
                end else if (grant_found) begin
                    pending_d[grant_idx] = 1'b0;
                    is_ref_d    = 1'b0;
                    chan_d      = grant_idx;
                    rr_ptr_d    = (grant_idx == c_cw'(N_CHAN - 1)) ? '0 : grant_idx + 1'b1;
                    instr_d     = {8'h00, 4'(grant_idx), shadow_q[grant_idx], 4'h0};
                    start_frame = 1'b1;
                end
                if (start_frame) begin
                    state_d   = S_LOAD;
                    nsync_d   = 1'b0;
                    sclk_d    = 1'b1;
                    din_d     = instr_d[31];
                    bit_cnt_d = 5'd31;
                    div_cnt_d = '0;
                end
            end
            // LOAD is the first cycle of bit 31's high half, so nSYNC stays
            // low for exactly 64*SCLK_DIV cycles.
            S_LOAD, S_SHIFT: begin
                state_d = S_SHIFT;
                if (div_cnt_q == c_div_last) begin
                    div_cnt_d = '0;
                    if (sclk_q) begin
                        sclk_d = 1'b0;
                    end else if (bit_cnt_q == 5'd0) begin
                        sclk_d    = 1'b1;
                        nsync_d   = 1'b1;
                        cyc_cnt_d = '0;
                        state_d   = S_SYNC_HI;
                    end else begin
                        sclk_d    = 1'b1;
                        bit_cnt_d = bit_cnt_q - 5'd1;
                        din_d     = instr_q[bit_cnt_q - 5'd1];
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 8'd1;
                end
            end
            S_SYNC_HI: begin
                if (cyc_cnt_q == c_sync_last) begin
                    cyc_cnt_d = '0;
                    if (is_ref_q) begin
                        state_d = S_IDLE;
                    end else begin
                        nldac_d = 1'b0;
                        state_d = S_LDAC;
                    end
                end else begin
                    cyc_cnt_d = cyc_cnt_q + 8'd1;
                end
            end
            S_LDAC: begin
                if (cyc_cnt_q == c_ldac_last) begin
                    cyc_cnt_d      = '0;
                    nldac_d        = 1'b1;
                    done_d[chan_q] = 1'b1;
                    state_d        = S_IDLE;
                end else begin
                    cyc_cnt_d = cyc_cnt_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Strobes are applied after the grant so a same-cycle strobe re-arms.
        if (bus.ref_set_in) begin
            ref_pending_d = 1'b1;
        end
        for (int i = 0; i < N_CHAN; i++) begin
            if (bus.data_valid_in[i]) begin
                shadow_d[i]  = bus.data_in[i*W_DATA +: W_DATA];
                pending_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q       <= S_IDLE;
            for (int i = 0; i < N_CHAN; i++) begin
                shadow_q[i] <= '0;
            end
            pending_q     <= '0;
            ref_pending_q <= 1'b0;
            rr_ptr_q      <= '0;
            chan_q        <= '0;
            is_ref_q      <= 1'b0;
            instr_q       <= '0;
            bit_cnt_q     <= '0;
            div_cnt_q     <= '0;
            cyc_cnt_q     <= '0;
            nsync_q       <= 1'b1;
            sclk_q        <= 1'b1;
            din_q         <= 1'b0;
            nldac_q       <= 1'b1;
            done_q        <= '0;
        end else begin
            state_q       <= state_d;
            for (int i = 0; i < N_CHAN; i++) begin
                shadow_q[i] <= shadow_d[i];
            end
            pending_q     <= pending_d;
            ref_pending_q <= ref_pending_d;
            rr_ptr_q      <= rr_ptr_d;
            chan_q        <= chan_d;
            is_ref_q      <= is_ref_d;
            instr_q       <= instr_d;
            bit_cnt_q     <= bit_cnt_d;
            div_cnt_q     <= div_cnt_d;
            cyc_cnt_q     <= cyc_cnt_d;
            nsync_q       <= nsync_d;
            sclk_q        <= sclk_d;
            din_q         <= din_d;
            nldac_q       <= nldac_d;
            done_q        <= done_d;
        end
    end

    assign bus.dac_nsync_out = nsync_q;
    assign bus.dac_sclk_out  = sclk_q;
    assign bus.dac_din_out   = din_q;
    assign bus.dac_nldac_out = nldac_q;
    assign bus.dac_nclr_out  = 1'b1;
    assign bus.busy_out      = (state_q != S_IDLE);
    assign bus.done_out      = done_q;
endmodule
`default_nettype wire
